// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative HI/LO multiply/divide unit. MULT/MULTU use 32-step shift-add
//   on operand magnitudes; DIV/DIVU use 32-step restoring division. The sign
//   of the result is fixed combinationally on the final iteration, so the
//   result lands on the 32nd enabled edge after the accept edge. MTHI/MTLO
//   write HI/LO directly in one edge.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; wins over clk_enable and start
//   clk_enable  0 freezes all state and outputs
//   start       request strobe, sampled with op/operand_a/operand_b
//   op          000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   operand_a   rs: multiplicand / dividend / MTHI-MTLO data
//   operand_b   rt: multiplier / divisor
//   busy        iterative operation in progress
//   done        one enabled-cycle pulse when HI/LO take a mul/div result
//   hi, lo      architectural HI and LO
//
// state   | meaning
// IDLE    | no operation in flight, accepts start
// MUL_RUN | shift-add multiply iterations
// DIV_RUN | restoring divide iterations
// FIX     | combinational only: sign correction + HI/LO write, then IDLE
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [31:0] w_hi, w_hi_nxt;      // product high half / partial remainder
    logic [31:0] w_lo, w_lo_nxt;      // multiplier bits / dividend-quotient
    logic [31:0] opnd, opnd_nxt;      // multiplicand or divisor magnitude
    logic        neg_main, neg_main_nxt;  // negate product or quotient
    logic        neg_rem, neg_rem_nxt;    // negate remainder (dividend sign)
    logic        div_zero, div_zero_nxt;
    logic [31:0] hi_nxt, lo_nxt;
    logic        done_nxt;

    // one iteration of each algorithm, evaluated from the current work regs
    logic [32:0] mul_sum;
    logic [31:0] mul_hi, mul_lo;
    logic [32:0] div_part;
    logic [33:0] div_diff;
    logic [31:0] div_rem, div_quo;

    logic        is_signed;
    logic [31:0] mag_a, mag_b;
    logic [63:0] prod, prod_fix;

    always_comb begin
        mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd} : 33'd0);
        mul_hi  = mul_sum[32:1];
        mul_lo  = {mul_sum[0], w_lo[31:1]};

        div_part = {w_hi, w_lo[31]};
        div_diff = {1'b0, div_part} - {2'b00, opnd};
        if (div_diff[33]) begin
            div_rem = div_part[31:0];
            div_quo = {w_lo[30:0], 1'b0};
        end else begin
            div_rem = div_diff[31:0];
            div_quo = {w_lo[30:0], 1'b1};
        end

        prod     = {mul_hi, mul_lo};
        prod_fix = neg_main ? (64'd0 - prod) : prod;
    end

    // MULT and DIV both work on magnitudes; 0x80000000 stays 0x80000000,
    // which is its correct unsigned magnitude.
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        mag_a = (is_signed && operand_a[31]) ? (32'd0 - operand_a) : operand_a;
        mag_b = (is_signed && operand_b[31]) ? (32'd0 - operand_b) : operand_b;
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        w_hi_nxt     = w_hi;
        w_lo_nxt     = w_lo;
        opnd_nxt     = opnd;
        neg_main_nxt = neg_main;
        neg_rem_nxt  = neg_rem;
        div_zero_nxt = div_zero;
        hi_nxt       = hi;
        lo_nxt       = lo;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_nxt    = op[1] ? DIV_RUN : MUL_RUN;
                            cnt_nxt      = 6'd0;
                            w_hi_nxt     = 32'd0;
                            // multiply: multiplier shifts out of w_lo;
                            // divide: dividend shifts out of w_lo
                            w_lo_nxt     = op[1] ? mag_a : mag_b;
                            opnd_nxt     = op[1] ? mag_b : mag_a;
                            neg_main_nxt = is_signed && (operand_a[31] ^ operand_b[31]);
                            neg_rem_nxt  = is_signed && operand_a[31];
                            div_zero_nxt = (operand_b == 32'd0);
                        end
                        OP_MTHI: hi_nxt = operand_a;
                        OP_MTLO: lo_nxt = operand_a;
                        default: ;
                    endcase
                end
            end
            MUL_RUN: begin
                w_hi_nxt = mul_hi;
                w_lo_nxt = mul_lo;
                cnt_nxt  = cnt + 6'd1;
                if (cnt == 6'd31)
                    state_nxt = FIX;
            end
            DIV_RUN: begin
                w_hi_nxt = div_rem;
                w_lo_nxt = div_quo;
                cnt_nxt  = cnt + 6'd1;
                if (cnt == 6'd31)
                    state_nxt = FIX;
            end
            default: state_nxt = IDLE;
        endcase

        // FIX resolves within the same edge as the last iteration.
        if (state_nxt == FIX) begin
            if (state == MUL_RUN) begin
                hi_nxt = prod_fix[63:32];
                lo_nxt = prod_fix[31:0];
            end else begin
                // divide by zero keeps the all-ones quotient unsigned; the
                // remainder path already reproduces operand_a
                lo_nxt = (neg_main && !div_zero) ? (32'd0 - div_quo) : div_quo;
                hi_nxt = neg_rem ? (32'd0 - div_rem) : div_rem;
            end
            done_nxt  = 1'b1;
            cnt_nxt   = 6'd0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            w_hi     <= 32'd0;
            w_lo     <= 32'd0;
            opnd     <= 32'd0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
        end else if (clk_enable) begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            w_hi     <= w_hi_nxt;
            w_lo     <= w_lo_nxt;
            opnd     <= opnd_nxt;
            neg_main <= neg_main_nxt;
            neg_rem  <= neg_rem_nxt;
            div_zero <= div_zero_nxt;
            hi       <= hi_nxt;
            lo       <= lo_nxt;
            done     <= done_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed test of mult_div_unit. Inputs change and outputs are sampled on
//   the falling edge; expected values are hand-computed constants.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi, m_lo;   // last architecturally committed HI/LO

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Accepts an op at the next edge N, scrambles operands, checks busy and
    // held HI/LO at N+31, optionally pokes an MTHI while busy, then checks
    // the done pulse at N+32. Returns right after edge N+32.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit poke_mthi);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        cyc(1);
        start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        chk1({tag, "_busy_accept"}, busy, 1'b1);
        cyc(31);
        chk1({tag, "_busy_n31"}, busy, 1'b1);
        chk1({tag, "_done_n31"}, done, 1'b0);
        chk32({tag, "_hi_held"}, hi, m_hi);
        chk32({tag, "_lo_held"}, lo, m_lo);
        if (poke_mthi) begin
            start = 1'b1; op = 3'b100; operand_a = 32'hA5A5A5A5;
        end
        cyc(1);
        start = 1'b0;
        chk1({tag, "_done"}, done, 1'b1);
        chk1({tag, "_busy_end"}, busy, 1'b0);
    endtask

    task automatic chk_result(input string tag, input logic [31:0] eh, input logic [31:0] el);
        chk32({tag, "_hi"}, hi, eh);
        chk32({tag, "_lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 3'b000;
        operand_a = 32'd0; operand_b = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        cyc(2);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk32("rst_hi", hi, 32'd0);
        chk32("rst_lo", lo, 32'd0);
        reset = 1'b0;

        // MULT -3*5 with an MTHI attempt while busy
        run_op("mult_m3x5", 3'b000, 32'hFFFFFFFD, 32'h00000005, 1'b1);
        chk_result("mult_m3x5", 32'hFFFFFFFF, 32'hFFFFFFF1);
        cyc(1);
        chk1("mult_done_drop", done, 1'b0);
        chk32("mthi_busy_ignored", hi, 32'hFFFFFFFF);

        // back-to-back: each new op accepted on the edge where done is high
        run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk_result("multu_max", 32'hFFFFFFFE, 32'h00000001);
        run_op("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        chk_result("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_by0", 3'b011, 32'h00001234, 32'h00000000, 1'b0);
        chk_result("divu_by0", 32'h00001234, 32'hFFFFFFFF);
        run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk_result("div_ovf", 32'h00000000, 32'h80000000);
        run_op("div_7_m2", 3'b010, 32'h00000007, 32'hFFFFFFFE, 1'b0);
        chk_result("div_7_m2", 32'h00000001, 32'hFFFFFFFD);
        run_op("div_neg_by0", 3'b010, 32'hFFFFFF00, 32'h00000000, 1'b0);
        chk_result("div_neg_by0", 32'hFFFFFF00, 32'hFFFFFFFF);
        run_op("mult_x_m1", 3'b000, 32'h12345678, 32'hFFFFFFFF, 1'b0);
        chk_result("mult_x_m1", 32'hFFFFFFFF, 32'hEDCBA988);
        run_op("mult_min2", 3'b000, 32'h80000000, 32'h80000000, 1'b0);
        chk_result("mult_min2", 32'h40000000, 32'h00000000);
        cyc(1);

        // MTLO / MTHI while idle
        start = 1'b1; op = 3'b101; operand_a = 32'h5A5A5A5A;
        cyc(1);
        start = 1'b0;
        chk32("mtlo_lo", lo, 32'h5A5A5A5A);
        chk32("mtlo_hi_kept", hi, 32'h40000000);
        chk1("mtlo_done", done, 1'b0);
        chk1("mtlo_busy", busy, 1'b0);
        start = 1'b1; op = 3'b100; operand_a = 32'hDEADBEEF;
        cyc(1);
        start = 1'b0;
        chk32("mthi_hi", hi, 32'hDEADBEEF);
        chk1("mthi_busy", busy, 1'b0);
        m_hi = 32'hDEADBEEF; m_lo = 32'h5A5A5A5A;

        // reserved ops
        start = 1'b1; op = 3'b110; operand_a = 32'h11111111; operand_b = 32'h22222222;
        cyc(1);
        chk1("rsv6_busy", busy, 1'b0);
        chk32("rsv6_hi", hi, 32'hDEADBEEF);
        chk32("rsv6_lo", lo, 32'h5A5A5A5A);
        op = 3'b111;
        cyc(1);
        start = 1'b0;
        chk1("rsv7_busy", busy, 1'b0);
        chk32("rsv7_hi", hi, 32'hDEADBEEF);
        chk32("rsv7_lo", lo, 32'h5A5A5A5A);

        // DIVU 100/7 with a 5-cycle clk_enable stall: result at edge N+37
        start = 1'b1; op = 3'b011; operand_a = 32'd100; operand_b = 32'd7;
        cyc(1);
        start = 1'b0;
        operand_a = 32'd0; operand_b = 32'd0;
        chk1("stall_busy_accept", busy, 1'b1);
        cyc(9);
        clk_enable = 1'b0;
        cyc(5);
        chk1("stall_busy_frozen", busy, 1'b1);
        clk_enable = 1'b1;
        cyc(22);
        chk1("stall_busy_n36", busy, 1'b1);
        chk1("stall_done_n36", done, 1'b0);
        chk32("stall_lo_held", lo, 32'h5A5A5A5A);
        cyc(1);
        chk1("stall_done_n37", done, 1'b1);
        chk_result("divu_100_7", 32'd2, 32'd14);
        clk_enable = 1'b0;
        cyc(3);
        chk1("done_frozen", done, 1'b1);
        clk_enable = 1'b1;
        cyc(1);
        chk1("done_after_unfreeze", done, 1'b0);

        // reset at iteration 10 of MULT
        start = 1'b1; op = 3'b000; operand_a = 32'd7; operand_b = 32'd9;
        cyc(1);
        start = 1'b0;
        cyc(9);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk32("abort_hi", hi, 32'd0);
        chk32("abort_lo", lo, 32'd0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        m_hi = 32'd0; m_lo = 32'd0;
        cyc(35);
        chk1("abort_no_late_done", done, 1'b0);
        chk32("abort_no_late_lo", lo, 32'd0);
        run_op("multu_3x4", 3'b001, 32'd3, 32'd4, 1'b0);
        chk_result("multu_3x4", 32'd0, 32'd12);
        cyc(1);

        // reset coincident with start wins
        start = 1'b1; op = 3'b100; operand_a = 32'h00000099;
        cyc(1);
        chk32("mthi_pre_rst", hi, 32'h00000099);
        reset = 1'b1; operand_a = 32'h00000077;
        cyc(1);
        reset = 1'b0; start = 1'b0;
        chk32("rst_start_hi", hi, 32'd0);
        chk1("rst_start_busy", busy, 1'b0);

        // reset acts even with clk_enable low
        start = 1'b1; op = 3'b101; operand_a = 32'h00000055;
        cyc(1);
        start = 1'b0;
        chk32("mtlo_pre_rst", lo, 32'h00000055);
        clk_enable = 1'b0; reset = 1'b1;
        cyc(1);
        reset = 1'b0; clk_enable = 1'b1;
        chk32("rst_ce0_lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
